// File: rtl/avg_filter_pkg.sv
// Shared constants and helpers for the moving-average filter.
// Holds the rounding-mode encodings, the accumulator width rule and the legal parameter ranges.
package avg_filter_pkg;

   localparam int unsigned ROUND_TRUNC   = 0;
   localparam int unsigned ROUND_HALF_UP = 1;

   // The sum of N samples needs log2(N) extra bits, so the accumulator can never overflow.
   function automatic int unsigned acc_width(int unsigned data_w, int unsigned log2_taps);
      return data_w + log2_taps;
   endfunction

   function automatic bit params_legal(int unsigned data_w, int unsigned log2_taps,
                                       int unsigned round_mode);
      return (data_w >= 2) && (data_w <= 32) && (log2_taps >= 1) && (log2_taps <= 8) &&
             (round_mode <= ROUND_HALF_UP);
   endfunction

endpackage

// File: rtl/moving_average_filter_if.sv
// Sample-stream bundle between a CE-strobed producer/consumer and the moving-average filter.
interface moving_average_filter_if #(
   parameter int unsigned DATA_W = 8
);
   logic                     i_ce;
   logic                     i_clear;
   logic signed [DATA_W-1:0] data_in;
   logic signed [DATA_W-1:0] data_out;
   logic                     o_ce;
   logic                     o_primed;

   modport master (output i_ce, i_clear, data_in, input data_out, o_ce, o_primed);
   modport slave  (input i_ce, i_clear, data_in, output data_out, o_ce, o_primed);
endinterface

// File: rtl/avg_delay_line.sv
// N-entry ring buffer with a saturating fill counter.
// The oldest sample reads as zero until N samples have been written, so startup acts as zero history.
module avg_delay_line
   import avg_filter_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned LOG2_TAPS = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic                     clear,
   input  logic signed [DATA_W-1:0] din,
   output logic signed [DATA_W-1:0] oldest_c,
   output logic                     almost_full_c
);

   localparam int unsigned N     = 1 << LOG2_TAPS;
   localparam int unsigned CNT_W = LOG2_TAPS + 1;

   logic        [LOG2_TAPS-1:0] wr_ptr;
   logic        [CNT_W-1:0]     fill;
   logic signed [DATA_W-1:0]    ring [N];

   // Pointer wraps naturally at N because its width is exactly LOG2_TAPS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         fill   <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         fill   <= '0;
      end else if (we) begin
         wr_ptr <= wr_ptr + LOG2_TAPS'(1);
         if (fill != CNT_W'(N)) fill <= fill + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (we && !clear) ring[wr_ptr] <= din;
   end

   assign oldest_c      = (fill == CNT_W'(N)) ? ring[wr_ptr] : '0;
   assign almost_full_c = (fill >= CNT_W'(N - 1));

endmodule

// File: rtl/moving_average_filter.sv
// N-tap boxcar filter: ring-buffer delay line feeding a running-sum accumulator,
// three-stage diff/accumulate/shift pipeline with one output strobe per accepted sample.
module moving_average_filter
   import avg_filter_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned LOG2_TAPS  = 2,
   parameter int unsigned ROUND_MODE = ROUND_TRUNC
) (
   input logic                    clk,
   input logic                    reset,
   moving_average_filter_if.slave bus
);

   localparam int unsigned ACC_W = acc_width(DATA_W, LOG2_TAPS);
   localparam logic signed [ACC_W-1:0] RND =
      (ROUND_MODE == ROUND_HALF_UP) ? (ACC_W'(1) << (LOG2_TAPS - 1)) : '0;

   if (!params_legal(DATA_W, LOG2_TAPS, ROUND_MODE)) begin : g_bad_params
      $error("moving_average_filter: illegal DATA_W/LOG2_TAPS/ROUND_MODE");
   end

   logic signed [DATA_W-1:0] oldest_c;
   logic                     almost_full_c;

   logic signed [ACC_W-1:0]  diff_r;
   logic                     ce_1;
   logic                     prim_0;
   logic signed [ACC_W-1:0]  acc;
   logic                     ce_2;
   logic                     prim_1;
   logic signed [DATA_W-1:0] data_out_r;
   logic                     o_ce_r;
   logic                     o_primed_r;
   logic signed [ACC_W-1:0]  rounded_c;

   avg_delay_line #(
      .DATA_W    (DATA_W),
      .LOG2_TAPS (LOG2_TAPS)
   ) u_delay (
      .clk           (clk),
      .reset         (reset),
      .we            (bus.i_ce),
      .clear         (bus.i_clear),
      .din           (bus.data_in),
      .oldest_c      (oldest_c),
      .almost_full_c (almost_full_c)
   );

   assign rounded_c = acc + RND;

   // Clear zeroes the CE chain so in-flight samples never reach the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         diff_r     <= '0;
         ce_1       <= 1'b0;
         prim_0     <= 1'b0;
         acc        <= '0;
         ce_2       <= 1'b0;
         prim_1     <= 1'b0;
         data_out_r <= '0;
         o_ce_r     <= 1'b0;
         o_primed_r <= 1'b0;
      end else if (bus.i_clear) begin
         diff_r     <= '0;
         ce_1       <= 1'b0;
         prim_0     <= 1'b0;
         acc        <= '0;
         ce_2       <= 1'b0;
         prim_1     <= 1'b0;
         data_out_r <= '0;
         o_ce_r     <= 1'b0;
         o_primed_r <= 1'b0;
      end else begin
         ce_1 <= bus.i_ce;
         if (bus.i_ce) begin
            diff_r <= ACC_W'(bus.data_in) - ACC_W'(oldest_c);
            prim_0 <= almost_full_c;
         end
         ce_2 <= ce_1;
         if (ce_1) begin
            acc    <= acc + diff_r;
            prim_1 <= prim_0;
         end
         o_ce_r <= ce_2;
         if (ce_2) begin
            data_out_r <= DATA_W'(rounded_c >>> LOG2_TAPS);
            o_primed_r <= prim_1;
         end
      end
   end

   assign bus.data_out = data_out_r;
   assign bus.o_ce     = o_ce_r;
   assign bus.o_primed = o_primed_r;

endmodule
